tile_shift_ctrl: RTL and testbench

TILE_SHIFT_CTRL -- requirements
Module: tile_shift_ctrl

---
 rtl/tile_shift_ctrl.sv | 145 ++++++++++++++
 tb/tb_tile_shift_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tile_shift_ctrl.sv
// Tile pixel shifter with a one-deep ROM fetch buffer and a fetch FSM.
// Optional horizontal flip enabled by defining TILE_SHIFT_FLIP_EN.
module tile_shift_ctrl #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_ce,
   input  logic              line_start,
   input  logic [ADDR_W-1:0] tile_base,
   input  logic              hflip,
   output logic              rom_req,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic              rom_ack,
   input  logic [15:0]       rom_data,
   output logic [1:0]        pixel,
   output logic              load,
   output logic              underrun,
   input  logic              underrun_clr
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_DISCARD} state_t;

   state_t      r_state, w_next;
   logic [2:0]  r_phase;
   logic [7:0]  r_p1, r_p0;
   logic        r_buf_valid;
   logic        r_load;
   logic        r_underrun;
   logic        w_flip;

`ifdef TILE_SHIFT_FLIP_EN
   localparam int BUF_W = 17;
   logic r_flip;
`else
   localparam int BUF_W = 16;
`endif

   logic [BUF_W-1:0] r_buf;
   logic [BUF_W-1:0] w_buf_in;

   logic w_restart, w_load_pt, w_ack_req, w_direct, w_fill, w_enter_req;

   assign w_restart   = pix_ce & line_start;
   assign w_load_pt   = pix_ce & ~line_start & (r_phase == 3'd7);
   assign w_ack_req   = rom_ack & (r_state == S_REQ);
   // Data arriving exactly at an empty load point bypasses the buffer.
   assign w_direct    = w_load_pt & ~r_buf_valid & w_ack_req;
   assign w_fill      = w_ack_req & ~w_restart & ~w_direct;
   assign w_enter_req = (r_state == S_IDLE) & (w_next == S_REQ);

`ifdef TILE_SHIFT_FLIP_EN
   assign w_buf_in = {hflip, rom_data};
   assign w_flip   = r_flip;

   always_ff @(posedge clk) begin
      if (rst)
         r_flip <= 1'b0;
      else if (w_load_pt)
         r_flip <= r_buf_valid ? r_buf[16] : (w_direct ? hflip : 1'b0);
   end
`else
   assign w_buf_in = rom_data;
   assign w_flip   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:         if (!r_buf_valid) w_next = S_REQ;
         // An ack coinciding with a restart is consumed and dropped here.
         S_REQ:          if (w_ack_req) w_next = S_IDLE;
                         else if (w_restart) w_next = S_WAIT_DISCARD;
         S_WAIT_DISCARD: if (rom_ack) w_next = S_IDLE;
         default:        w_next = S_IDLE;
      endcase
   end

   always_comb begin
      rom_req = (r_state != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst)
         rom_addr <= '0;
      else if (w_enter_req)
         rom_addr <= tile_base;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_phase     <= 3'd0;
         r_p1        <= 8'd0;
         r_p0        <= 8'd0;
         r_buf       <= '0;
         r_buf_valid <= 1'b0;
         r_load      <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_load <= w_load_pt;

         if (w_fill)
            r_buf <= w_buf_in;
         if (w_restart || (w_load_pt && r_buf_valid))
            r_buf_valid <= 1'b0;
         else if (w_fill)
            r_buf_valid <= 1'b1;

         if (w_restart)
            r_phase <= 3'd0;
         else if (pix_ce)
            r_phase <= r_phase + 3'd1;

         if (w_load_pt) begin
            if (r_buf_valid)   {r_p1, r_p0} <= r_buf[15:0];
            else if (w_direct) {r_p1, r_p0} <= rom_data;
            else               {r_p1, r_p0} <= 16'd0;
         end else if (pix_ce && !line_start) begin
            if (w_flip) begin
               r_p1 <= {1'b0, r_p1[7:1]};
               r_p0 <= {1'b0, r_p0[7:1]};
            end else begin
               r_p1 <= {r_p1[6:0], 1'b0};
               r_p0 <= {r_p0[6:0], 1'b0};
            end
         end

         // Set takes priority over a coincident clear.
         if (w_load_pt && !r_buf_valid && !w_direct)
            r_underrun <= 1'b1;
         else if (underrun_clr)
            r_underrun <= 1'b0;
      end
   end

   assign pixel    = w_flip ? {r_p1[0], r_p0[0]} : {r_p1[7], r_p0[7]};
   assign load     = r_load;
   assign underrun = r_underrun;

endmodule

// File: tb/tb_tile_shift_ctrl.sv
// Directed bench for tile_shift_ctrl: fetch, shift order, underrun,
// direct load, line restart discard and reset with a stray ack.
module tb_tile_shift_ctrl;

   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              rst, pix_ce, line_start, hflip, rom_ack, underrun_clr;
   logic [ADDR_W-1:0] tile_base;
   logic [15:0]       rom_data;
   logic              rom_req, load, underrun;
   logic [ADDR_W-1:0] rom_addr;
   logic [1:0]        pixel;

   int errors = 0;
   int checks = 0;

   tile_shift_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .pix_ce(pix_ce), .line_start(line_start),
      .tile_base(tile_base), .hflip(hflip), .rom_req(rom_req),
      .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
      .pixel(pixel), .load(load), .underrun(underrun),
      .underrun_clr(underrun_clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [1:0] seq_left [8];
   logic [1:0] seq_flip [8];

   initial begin
      seq_left = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
      seq_flip = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3};

      rst = 1'b1; pix_ce = 1'b0; line_start = 1'b0; hflip = 1'b0;
      rom_ack = 1'b0; underrun_clr = 1'b0; tile_base = 12'h123; rom_data = 16'h0;
      tick(); tick();
      chk("rst_req", rom_req, 0);
      chk("rst_addr", rom_addr, 0);
      chk("rst_pixel", pixel, 0);
      chk("rst_load", load, 0);
      chk("rst_underrun", underrun, 0);

      // First fetch
      rst = 1'b0;
      tick();
      chk("req_issued", rom_req, 1);
      chk("req_addr", rom_addr, 12'h123);
      rom_ack = 1'b1; rom_data = 16'h80F0; hflip = 1'b0;
      tick();
      rom_ack = 1'b0;
      chk("idle_buf_full", rom_req, 0);

      pix_ce = 1'b1;
      for (int i = 0; i < 20 && !load; i++) tick();
      chk("load_seen", load, 1);
      chk("pix_left_0", pixel, seq_left[0]);
      for (int k = 1; k < 8; k++) begin
         tick();
         chk($sformatf("pix_left_%0d", k), pixel, seq_left[k]);
      end

      // Withheld ack -> underrun with zero pixels
      tick();
      chk("ur_load", load, 1);
      chk("ur_pixel", pixel, 0);
      chk("ur_flag", underrun, 1);
      for (int k = 1; k < 8; k++) begin
         tick();
         chk($sformatf("ur_pix_%0d", k), pixel, 0);
      end
      chk("ur_sticky", underrun, 1);
      underrun_clr = 1'b1;
      tick();
      chk("ur_set_wins", underrun, 1);
      chk("ur_load2", load, 1);
      underrun_clr = 1'b0; pix_ce = 1'b0;
      tick();
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      chk("ur_cleared", underrun, 0);
      tick();
      chk("hold_load", load, 0);

      // Direct load at the phase-7 edge
      pix_ce = 1'b1;
      repeat (7) tick();
      chk("pre_direct_load", load, 0);
      rom_ack = 1'b1; rom_data = 16'hFFFF;
      tick();
      rom_ack = 1'b0; pix_ce = 1'b0;
      chk("direct_load", load, 1);
      chk("direct_pixel", pixel, 3);
      chk("direct_no_ur", underrun, 0);
      chk("direct_idle", rom_req, 0);
      tick();
      chk("direct_refetch", rom_req, 1);
      chk("direct_hold_pix", pixel, 3);

      // Line restart while requesting
      tile_base = 12'h200;
      line_start = 1'b1; pix_ce = 1'b1;
      tick();
      line_start = 1'b0; pix_ce = 1'b0;
      chk("wd_req_held", rom_req, 1);
      rom_ack = 1'b1; rom_data = 16'hFFFF;
      tick();
      rom_ack = 1'b0;
      chk("wd_idle", rom_req, 0);
      tick();
      chk("wd_new_req", rom_req, 1);
      chk("wd_new_addr", rom_addr, 12'h200);
      rom_ack = 1'b1; rom_data = 16'h80F0; hflip = 1'b1;
      tick();
      rom_ack = 1'b0; hflip = 1'b0;
      pix_ce = 1'b1;
      repeat (7) tick();
      chk("restart_no_load", load, 0);
      tick();
      chk("restart_load", load, 1);
      chk("restart_no_ur", underrun, 0);
`ifdef TILE_SHIFT_FLIP_EN
      chk("pix_flip_0", pixel, seq_flip[0]);
      for (int k = 1; k < 8; k++) begin
         tick();
         chk($sformatf("pix_flip_%0d", k), pixel, seq_flip[k]);
      end
`else
      chk("pix_noflip_0", pixel, seq_left[0]);
      for (int k = 1; k < 8; k++) begin
         tick();
         chk($sformatf("pix_noflip_%0d", k), pixel, seq_left[k]);
      end
`endif
      pix_ce = 1'b0;

      // Reset during an outstanding request, then a stray ack
      chk("pre_rst_req", rom_req, 1);
      rst = 1'b1;
      tick();
      chk("rst_drop_req", rom_req, 0);
      chk("rst2_pixel", pixel, 0);
      chk("rst2_load", load, 0);
      rst = 1'b0; rom_ack = 1'b1; rom_data = 16'hFFFF;
      tick();
      rom_ack = 1'b0;
      chk("stray_rereq", rom_req, 1);
      chk("stray_no_ur", underrun, 0);
      pix_ce = 1'b1;
      repeat (8) tick();
      pix_ce = 1'b0;
      chk("stray_load", load, 1);
      chk("stray_ignored_ur", underrun, 1);
      chk("stray_pixel", pixel, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
